seven_seg_scan_ctrl: RTL and testbench

//  Scan scheduler for the 8-digit seven-segment display. Time-multiplexes the

---
 rtl/disp_pkg.sv | 9 +
 rtl/scan_timebase.sv | 49 ++++
 rtl/seven_seg_scan_ctrl.sv | 119 +++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package disp_pkg;
    localparam int NIB_W      = 4;
    localparam int PWM_PHASES = 16;

    typedef logic [2:0]       digit_idx_t;
    typedef logic [NIB_W-1:0] nibble_t;
    typedef logic [3:0]       bright_t;
endpackage

// File: rtl/scan_timebase.sv
// Slot/phase/digit counters for the display scan; emits slot and frame end strobes.
module scan_timebase
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk_in,
    input  logic       reset,
    output logic [3:0] phase,
    output logic [2:0] digit_idx,
    output logic       slot_end,
    output logic       frame_end
);
    localparam int CNT_W     = $clog2(REFRESH_DIV);
    localparam int PHASE_LEN = REFRESH_DIV / PWM_PHASES;
    localparam int SUB_W     = $clog2(PHASE_LEN);

    logic [CNT_W-1:0] slot_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic             phase_end;

    assign slot_end  = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
    assign phase_end = (sub_cnt == SUB_W'(PHASE_LEN - 1));
    assign frame_end = slot_end && (digit_idx == 3'(N_DIGITS - 1));

    // phase is tracked by a sub-counter so REFRESH_DIV/16 need not be a power of two
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            slot_cnt  <= '0;
            sub_cnt   <= '0;
            phase     <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            slot_cnt  <= '0;
            sub_cnt   <= '0;
            phase     <= '0;
            digit_idx <= frame_end ? 3'd0 : digit_idx + 3'd1;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
            if (phase_end) begin
                sub_cnt <= '0;
                phase   <= phase + 4'd1;
            end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
            end
        end
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-seg scan scheduler: tear-free value/config updates, PWM dimming,
// leading-zero blanking and a one-cycle ghosting guard at each slot start.
module seven_seg_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic [NIB_W*N_DIGITS-1:0] upd_value,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [N_DIGITS-1:0]       en_mask,
    input  logic [BRIGHT_W-1:0]       brightness,
    input  logic                      blank_lz,
    output logic [3:0]                digit_nib,
    output logic [2:0]                digit_sel,
    output logic [N_DIGITS-1:0]       an,
    output logic                      frame_start
);
    localparam int VAL_W = NIB_W * N_DIGITS;

    logic [3:0]          phase;
    digit_idx_t          digit_idx;
    logic                slot_end;
    logic                frame_end;
    logic                slot_first;
    logic                frame_entry;
    logic [VAL_W-1:0]    pending_val;
    logic [VAL_W-1:0]    active_val;
    logic [N_DIGITS-1:0] act_mask;
    logic [BRIGHT_W-1:0] act_bright;
    logic                act_blank_lz;
    logic [N_DIGITS-1:0] lz_zero;
    logic                lz_run;
    nibble_t             nib_cur;
    logic [N_DIGITS-1:0] an_next;

    scan_timebase #(
        .N_DIGITS    (N_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timebase (
        .clk_in    (clk_in),
        .reset     (reset),
        .phase     (phase),
        .digit_idx (digit_idx),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    // Handshake: a transfer happens on any clock where upd_valid && upd_ready.
    // upd_ready is high exactly while the single pending slot is empty; it is
    // refilled-able again only after the frame boundary promotes pending to active.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pending_val  <= '0;
            active_val   <= '0;
            upd_ready    <= 1'b1;
            act_mask     <= '1;
            act_bright   <= '1;
            act_blank_lz <= 1'b0;
            slot_first   <= 1'b1;
            frame_entry  <= 1'b1;
        end else begin
            slot_first  <= slot_end;
            frame_entry <= frame_end;
            if (frame_end) begin
                act_mask     <= en_mask;
                act_bright   <= brightness;
                act_blank_lz <= blank_lz;
                if (!upd_ready) begin
                    active_val <= pending_val;
                    upd_ready  <= 1'b1;
                end
            end
            if (upd_valid && upd_ready) begin
                pending_val <= upd_value;
                upd_ready   <= 1'b0;
            end
        end
    end

    // lz_zero[i]: active nibbles i..N_DIGITS-1 are all zero
    always_comb begin
        lz_zero = '0;
        lz_run  = 1'b1;
        nib_cur = '0;
        an_next = '1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run && (active_val[i*NIB_W +: NIB_W] == '0);
            lz_zero[i] = lz_run;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == 3'(i)) begin
                nib_cur = active_val[i*NIB_W +: NIB_W];
                if (!slot_first && act_mask[i] && (phase <= 4'(act_bright))
                    && !(act_blank_lz && (i != 0) && lz_zero[i])) begin
                    an_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            an          <= '1;
            digit_sel   <= '0;
            digit_nib   <= '0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            digit_sel   <= digit_idx;
            digit_nib   <= nib_cur;
            frame_start <= frame_entry;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with an 8-digit, 32-cycle-slot configuration.
module tb_seven_seg_scan_ctrl;
  localparam int SLOT  = 32;
  localparam int FRAME = 256;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] upd_value = '0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [7:0]  en_mask = 8'hFF;
  logic [3:0]  brightness = 4'hF;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit_nib;
  logic [2:0]  digit_sel;
  logic [7:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // reference model state; m_* is the state after the last edge, d_* the state the outputs reflect
  int          m_n = 0;
  logic        m_ready = 1'b1;
  logic [31:0] m_val = '0, d_val = '0;
  logic [7:0]  m_mask = 8'hFF, d_mask = 8'hFF;
  logic [3:0]  m_bright = 4'hF, d_bright = 4'hF;
  logic        m_blz = 1'b0, d_blz = 1'b0;
  logic        mdl_accept;
  logic        mdl_boundary;
  logic [31:0] exp_q[$];

  seven_seg_scan_ctrl #(
    .N_DIGITS    (8),
    .REFRESH_DIV (SLOT),
    .BRIGHT_W    (4)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .upd_value   (upd_value),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .en_mask     (en_mask),
    .brightness  (brightness),
    .blank_lz    (blank_lz),
    .digit_nib   (digit_nib),
    .digit_sel   (digit_sel),
    .an          (an),
    .frame_start (frame_start)
  );

  // clock / reset
  initial forever #5 clk_in = ~clk_in;

  // model: counts edges, tracks the pending slot via the scoreboard queue
  initial forever begin
    @(posedge clk_in or negedge reset);
    if (!reset) begin
      m_n = 0; m_ready = 1'b1; exp_q.delete();
      m_val = '0; m_mask = 8'hFF; m_bright = 4'hF; m_blz = 1'b0;
      d_val = '0; d_mask = 8'hFF; d_bright = 4'hF; d_blz = 1'b0;
    end else begin
      d_val = m_val; d_mask = m_mask; d_bright = m_bright; d_blz = m_blz;
      mdl_accept = upd_valid && m_ready;
      mdl_boundary = (m_n % FRAME) == FRAME - 1;
      if (mdl_boundary) begin
        m_mask = en_mask; m_bright = brightness; m_blz = blank_lz;
        if (!m_ready) begin
          if (exp_q.size() > 0) m_val = exp_q.pop_front();
          m_ready = 1'b1;
        end
      end
      if (mdl_accept) begin
        exp_q.push_back(upd_value);
        m_ready = 1'b0;
      end
      m_n++;
    end
  end

  function automatic logic [7:0] exp_an();
    int o, dig, pos;
    logic [7:0] a;
    a = 8'hFF;
    if (m_n == 0) return a;
    o = m_n - 1; dig = (o / SLOT) % 8; pos = o % SLOT;
    if (pos != 0 && pos < (int'(d_bright) + 1) * (SLOT / 16) && d_mask[dig]
        && !(dig > 0 && d_blz && (d_val >> (4 * dig)) == 32'h0))
      a[dig] = 1'b0;
    return a;
  endfunction

  function automatic logic [2:0] exp_sel();
    if (m_n == 0) return 3'd0;
    return 3'(((m_n - 1) / SLOT) % 8);
  endfunction

  function automatic logic [3:0] exp_nib();
    if (m_n == 0) return 4'h0;
    return 4'((d_val >> (4 * (((m_n - 1) / SLOT) % 8))) & 32'hF);
  endfunction

  function automatic logic exp_fs();
    return (m_n > 0) && ((m_n - 1) % FRAME == 0);
  endfunction

  // driver tasks
  task automatic drive_update(input logic [31:0] v, output int acc_n);
    logic took;
    took = 1'b0;
    upd_value = v; upd_valid = 1'b1;
    for (int c = 0; c < 2000 && !took; c++) begin
      took = upd_ready;
      @(negedge clk_in);
    end
    upd_valid = 1'b0;
    acc_n = m_n;
    if (!took) begin
      checks++; errors++;
      $display("FAIL handshake_timeout value %h never accepted", v);
    end
  endtask

  task automatic wait_internal(input int p);
    for (int c = 0; c < 600 && (m_n % FRAME) != p; c++) @(negedge clk_in);
  endtask

  task automatic wait_pos(input int p);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      if (m_n > 0 && ((m_n - 1) % FRAME) == p) break;
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", an); end
    checks++; if (digit_sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", digit_sel); end
    checks++; if (digit_nib !== 4'h0) begin errors++; $display("FAIL reset_nib got %h want 0", digit_nib); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", upd_ready); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
    reset = 1'b1;
  endtask

  task automatic test_scan();
    int fs_seen;
    fs_seen = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      if (frame_start === 1'b1) fs_seen++;
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL scan n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
    checks++; if (fs_seen != 3) begin errors++; $display("FAIL scan_fs_count got %0d want 3", fs_seen); end
  endtask

  task automatic test_update();
    int acc;
    wait_internal(100);
    drive_update(32'h1234_ABCD, acc);
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL upd_ready_fall got %b want 0", upd_ready); end
    for (int c = 0; c < 500; c++) begin
      @(negedge clk_in);
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL update n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
    wait_pos(5);
    checks++; if (digit_nib !== 4'hD) begin errors++; $display("FAIL update_digit0 got %h want d", digit_nib); end
    wait_pos(7 * SLOT + 5);
    checks++; if (digit_nib !== 4'h1) begin errors++; $display("FAIL update_digit7 got %h want 1", digit_nib); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL update_ready_back got %b want 1", upd_ready); end
  endtask

  task automatic test_back_to_back();
    int acc;
    wait_internal(50);
    drive_update(32'h0F0F_0F0F, acc);
    drive_update(32'hFFFF_FFFF, acc);
    checks++; if (acc % FRAME != 1) begin errors++; $display("FAIL b2b_accept_pos got %0d want 1", acc % FRAME); end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL b2b n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
    // capture in the boundary cycle itself must wait a full frame
    wait_internal(FRAME - 1);
    upd_value = 32'h8765_4321; upd_valid = 1'b1;
    @(negedge clk_in);
    upd_valid = 1'b0;
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL boundary_capture_ready got %b want 0", upd_ready); end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL boundary n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
  endtask

  task automatic test_blanking();
    int acc;
    blank_lz = 1'b1;
    drive_update(32'h0000_0105, acc);
    for (int c = 0; c < 700; c++) begin
      @(negedge clk_in);
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL blank n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
    wait_pos(2 * SLOT + 10);
    checks++; if (an !== 8'hFB) begin errors++; $display("FAIL blank_digit2 got %h want fb", an); end
    wait_pos(3 * SLOT + 10);
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL blank_digit3 got %h want ff", an); end
    drive_update(32'h0, acc);
    for (int c = 0; c < 700; c++) begin
      @(negedge clk_in);
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL blank0 n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
    wait_pos(10);
    checks++; if (an !== 8'hFE) begin errors++; $display("FAIL blank0_digit0 got %h want fe", an); end
    wait_pos(SLOT + 10);
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL blank0_digit1 got %h want ff", an); end
  endtask

  task automatic test_brightness();
    int acc;
    blank_lz = 1'b0; brightness = 4'd3;
    drive_update(32'h89AB_CDEF, acc);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL bright3 n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
    wait_pos(SLOT);
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL bright3_guard got %h want ff", an); end
    wait_pos(SLOT + 1);
    checks++; if (an !== 8'hFD) begin errors++; $display("FAIL bright3_first got %h want fd", an); end
    wait_pos(SLOT + 7);
    checks++; if (an !== 8'hFD) begin errors++; $display("FAIL bright3_last got %h want fd", an); end
    wait_pos(SLOT + 8);
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL bright3_off got %h want ff", an); end
    brightness = 4'd15; en_mask = 8'hFE;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL bright15 n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
    wait_pos(5);
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL mask_digit0 got %h want ff", an); end
    wait_pos(2 * SLOT - 1);
    checks++; if (an !== 8'hFD) begin errors++; $display("FAIL bright15_last got %h want fd", an); end
    en_mask = 8'hFF;
  endtask

  task automatic test_reset_mid();
    int acc;
    wait_internal(100);
    drive_update(32'hFFFF_FFFF, acc);
    #3 reset = 1'b0;
    #1;
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL async_an got %h want ff", an); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b want 1", upd_ready); end
    checks++; if (digit_nib !== 4'h0) begin errors++; $display("FAIL async_nib got %h want 0", digit_nib); end
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    checks++; if (digit_sel !== 3'd0 || frame_start !== 1'b1) begin errors++; $display("FAIL restart sel %0d fs %b want 0 1", digit_sel, frame_start); end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      checks++;
      if (an !== exp_an() || digit_sel !== exp_sel() || digit_nib !== exp_nib() || frame_start !== exp_fs() || upd_ready !== m_ready) begin
        errors++;
        $display("FAIL post_reset n=%0d an %h want %h sel %0d want %0d nib %h want %h fs %b want %b rdy %b want %b",
                 m_n - 1, an, exp_an(), digit_sel, exp_sel(), digit_nib, exp_nib(), frame_start, exp_fs(), upd_ready, m_ready);
      end
    end
    wait_pos(7 * SLOT + 5);
    checks++; if (digit_nib !== 4'h0) begin errors++; $display("FAIL pending_dropped got %h want 0", digit_nib); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_scan();
    test_update();
    test_back_to_back();
    test_blanking();
    test_brightness();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
